hq2x_linebuf: RTL and testbench



---
 rtl/hq2x_linebuf.sv | 92 +++++++++
 tb/tb_hq2x_linebuf.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/hq2x_linebuf.sv
// Multi-line ring buffer for the hq2x scaler: stores the last NUMLINES lines and
// reads one column from every previously completed line each clock.
module hq2x_linebuf #(
    parameter int unsigned NUMLINES = 3,
    parameter int unsigned NUMWORDS = 512,
    parameter int unsigned AWIDTH   = 9,
    parameter int unsigned DWIDTH   = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           sof,
    input  logic                           wr_en,
    input  logic [AWIDTH-1:0]              wr_addr,
    input  logic [DWIDTH-1:0]              wr_data,
    input  logic                           wr_eol,
    input  logic [AWIDTH-1:0]              rd_addr,
    output logic [(NUMLINES-1)*DWIDTH-1:0] q,
    output logic [NUMLINES-2:0]            q_valid,
    output logic                           wr_ovf
);

    localparam int unsigned TAPS = NUMLINES - 1;
    localparam int unsigned LW   = $clog2(NUMLINES);
    localparam int unsigned VW   = LW + 1;
    localparam int unsigned IW   = $clog2(NUMWORDS);

    logic [LW-1:0]     wr_line;
    logic [VW-1:0]     lines_valid;
    logic [DWIDTH-1:0] mem [NUMLINES][NUMWORDS];

    logic              wr_in_range_c;
    logic              rd_in_range_c;
    logic [LW-1:0]     wr_bank_c;

    assign wr_in_range_c = {1'b0, wr_addr} < (AWIDTH+1)'(NUMWORDS);
    assign rd_in_range_c = {1'b0, rd_addr} < (AWIDTH+1)'(NUMWORDS);
    // sof restarts the frame in line 0 even for a write in the same cycle
    assign wr_bank_c     = sof ? '0 : wr_line;

    // Bank holding the line k+1 lines behind the write line, modulo NUMLINES
    function automatic logic [LW-1:0] tap_line(input logic [LW-1:0] line, input int unsigned k);
        int unsigned idx;
        idx = 32'(line) + NUMLINES - 1 - k;
        if (idx >= NUMLINES) begin
            idx = idx - NUMLINES;
        end
        return LW'(idx);
    endfunction

    always_ff @(posedge clock) begin
        if (wr_en && wr_in_range_c) begin
            mem[wr_bank_c][wr_addr[IW-1:0]] <= wr_data;
        end
    end

    // Line pointer, validity count and sticky overflow
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_line     <= '0;
            lines_valid <= '0;
            wr_ovf      <= 1'b0;
        end else begin
            if (sof) begin
                wr_line     <= '0;
                lines_valid <= '0;
            end else if (wr_eol) begin
                wr_line     <= (wr_line == LW'(NUMLINES - 1)) ? '0 : wr_line + LW'(1);
                lines_valid <= (lines_valid == VW'(TAPS)) ? lines_valid : lines_valid + VW'(1);
            end
            if (wr_en && !wr_in_range_c) begin
                wr_ovf <= 1'b1;
            end else if (sof) begin
                wr_ovf <= 1'b0;
            end
        end
    end

    // Registered tap reads; taps never address the write line so no bypass is needed
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q       <= '0;
            q_valid <= '0;
        end else begin
            for (int k = 0; k < int'(TAPS); k++) begin
                q_valid[k] <= lines_valid > VW'(k);
                q[k*DWIDTH +: DWIDTH] <= rd_in_range_c ?
                    mem[tap_line(wr_line, k)][rd_addr[IW-1:0]] : '0;
            end
        end
    end

endmodule

// File: tb/tb_hq2x_linebuf.sv
// Self-checking bench for hq2x_linebuf: directed scenarios plus random traffic
// compared against a line-history model.
module tb_hq2x_linebuf;

    localparam int NL = 3;
    localparam int NW = 512;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int T  = NL - 1;

    logic            clock = 1'b0;
    logic            reset;
    logic            sof;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            wr_eol;
    logic [AW-1:0]   rd_addr;
    logic [T*DW-1:0] q;
    logic [T-1:0]    q_valid;
    logic            wr_ovf;

    int checks   = 0;
    int failures = 0;

    // Model: contents of each physical line slot, plus which words are known
    logic [DW-1:0] mm [NL][NW];
    bit            kn [NL][NW];
    int            m_line;
    int            m_valid;
    bit            m_ovf;

    hq2x_linebuf #(.NUMLINES(NL), .NUMWORDS(NW), .AWIDTH(AW), .DWIDTH(DW)) dut (
        .clock   (clock),
        .reset   (reset),
        .sof     (sof),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_eol  (wr_eol),
        .rd_addr (rd_addr),
        .q       (q),
        .q_valid (q_valid),
        .wr_ovf  (wr_ovf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] tap(input int k);
        logic [T*DW-1:0] v;
        v = q;
        return v[k*DW +: DW];
    endfunction

    // One clock: drive inputs, predict, advance model, sample 1ns after the edge
    task automatic cyc(input bit s, input bit we, input int wa, input int wd,
                       input bit eol, input int ra);
        logic [DW-1:0] eq [T];
        bit            ek [T];
        logic [T-1:0]  ev;
        int            b;
        sof     = s;
        wr_en   = we;
        wr_addr = AW'(wa);
        wr_data = DW'(wd);
        wr_eol  = eol;
        rd_addr = AW'(ra);
        for (int k = 0; k < T; k++) begin
            b     = (m_line - 1 - k + NL) % NL;
            ev[k] = (m_valid > k);
            if (ra < NW) begin
                eq[k] = mm[b][ra];
                ek[k] = kn[b][ra];
            end else begin
                eq[k] = '0;
                ek[k] = 1'b1;
            end
        end
        if (we && wa < NW) begin
            b         = s ? 0 : m_line;
            mm[b][wa] = DW'(wd);
            kn[b][wa] = 1'b1;
        end
        if (s) m_ovf = 1'b0;
        if (we && wa >= NW) m_ovf = 1'b1;
        if (s) begin
            m_line  = 0;
            m_valid = 0;
        end else if (eol) begin
            m_line  = (m_line + 1) % NL;
            m_valid = (m_valid + 1 > T) ? T : m_valid + 1;
        end
        @(posedge clock);
        #1;
        chk("q_valid", 32'(q_valid), 32'(ev));
        chk("wr_ovf", 32'(wr_ovf), 32'(m_ovf));
        for (int k = 0; k < T; k++) begin
            if (ek[k]) chk($sformatf("tap%0d@%0d", k, ra), 32'(tap(k)), 32'(eq[k]));
        end
    endtask

    task automatic rd(input int ra);
        cyc(1'b0, 1'b0, 0, 0, 1'b0, ra);
    endtask

    // Write a full line; eol either with the last pixel or as its own cycle
    task automatic write_line(input int base, input bit rnd, input bit eol_last);
        for (int col = 0; col < NW; col++) begin
            cyc(1'b0, 1'b1, col, rnd ? int'($urandom_range(0, 255)) : base + col,
                eol_last && col == NW - 1, int'($urandom_range(0, 1023)));
        end
        if (!eol_last) cyc(1'b0, 1'b0, 0, 0, 1'b1, int'($urandom_range(0, 1023)));
    endtask

    initial begin
        for (int b = 0; b < NL; b++)
            for (int c = 0; c < NW; c++) kn[b][c] = 1'b0;
        m_line  = 0;
        m_valid = 0;
        m_ovf   = 1'b0;
        reset   = 1'b1;
        sof     = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_eol  = 1'b0;
        rd_addr = '0;
        #12;
        chk("reset_q", 32'(q), 32'h0);
        chk("reset_q_valid", 32'(q_valid), 32'h0);
        chk("reset_wr_ovf", 32'(wr_ovf), 32'h0);
        reset = 1'b0;

        // Fill: line A with separate eol, line B with eol on the last pixel
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 0);
        write_line(8'h10, 1'b0, 1'b0);
        write_line(8'h80, 1'b0, 1'b1);
        rd(5);
        chk("fill_tap0", 32'(tap(0)), 32'h85);
        chk("fill_tap1", 32'(tap(1)), 32'h15);
        chk("fill_valid", 32'(q_valid), 32'h3);
        rd(511);
        chk("eol_write_tap0", 32'(tap(0)), 32'h7f);

        // Validity ramp
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 0);
        rd(7);
        chk("ramp_none", 32'(q_valid), 32'h0);
        write_line(8'h20, 1'b0, 1'b0);
        rd(7);
        chk("ramp_one", 32'(q_valid), 32'h1);
        chk("ramp_tap0", 32'(tap(0)), 32'h27);

        // Wrap: four random lines after sof, then a fifth eol
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 0);
        for (int i = 0; i < 4; i++) write_line(0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) rd(int'($urandom_range(0, 1023)));
        cyc(1'b0, 1'b0, 0, 0, 1'b1, 0);
        rd(100);
        chk("saturate", 32'(q_valid), 32'h3);

        // sof with eol: eol ignored, frame restarts at line 0
        cyc(1'b1, 1'b0, 0, 0, 1'b1, 0);
        rd(3);
        chk("sof_eol_valid", 32'(q_valid), 32'h0);
        write_line(8'h40, 1'b0, 1'b1);
        rd(3);
        chk("sof_eol_tap0", 32'(tap(0)), 32'h43);

        // Overflow: no aliasing write, sticky flag, out-of-range read is zero
        cyc(1'b0, 1'b1, 600, 8'haa, 1'b0, 88);
        chk("ovf_set", 32'(wr_ovf), 32'h1);
        rd(600);
        chk("ovf_rd_zero", 32'(q), 32'h0);
        rd(88);
        rd(600);
        chk("ovf_hold", 32'(wr_ovf), 32'h1);
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 88);
        chk("ovf_clear", 32'(wr_ovf), 32'h0);

        // Async reset mid-line with the flag set and taps non-zero
        write_line(0, 1'b1, 1'b0);
        write_line(0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 700, 0, 1'b0, 9);
        for (int col = 0; col < 50; col++) cyc(1'b0, 1'b1, col, col ^ 8'h5a, 1'b0, col);
        #2;
        reset = 1'b1;
        #1;
        chk("async_q", 32'(q), 32'h0);
        chk("async_valid", 32'(q_valid), 32'h0);
        chk("async_ovf", 32'(wr_ovf), 32'h0);
        #1;
        reset   = 1'b0;
        m_line  = 0;
        m_valid = 0;
        m_ovf   = 1'b0;
        write_line(8'h60, 1'b0, 1'b1);
        rd(2);
        chk("post_reset_tap0", 32'(tap(0)), 32'h62);
        cyc(1'b0, 1'b0, 0, 0, 1'b1, 2);
        rd(2);
        rd(513);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit s;
            bit we;
            s  = ($urandom_range(0, 199) == 0);
            we = !s && ($urandom_range(0, 3) != 0);
            cyc(s, we, int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)),
                ($urandom_range(0, 99) == 0), int'($urandom_range(0, 1023)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
